result_streamer: RTL and testbench

//  Downstream drain stage for the dot-product output memory. It waits for the

---
 rtl/result_streamer_if.sv | 12 +
 rtl/result_streamer.sv | 122 ++++++++++++
 tb/tb_result_streamer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_streamer_if.sv
// Valid/ready stream carrying result words plus an end-of-frame flag.
interface result_streamer_if #(
    parameter int unsigned DataWidth = 18
) ();
    logic                 valid;
    logic                 ready;
    logic [DataWidth-1:0] data;
    logic                 last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/result_streamer.sv
// Drains NUM_RESULTS words from the output memory into a valid/ready stream.
// Optional per-frame checksum is built only when RESULT_CHECKSUM_EN is defined.
module result_streamer #(
    parameter int unsigned RESULT_WIDTH    = 18,
    parameter int unsigned MEM3_ADDR_WIDTH = 4,
    parameter int unsigned NUM_RESULTS     = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    writer_done_i,
    output logic                                    read_en_o,
    output logic [MEM3_ADDR_WIDTH-1:0]              read_addr_o,
    input  logic [RESULT_WIDTH-1:0]                 result_out_i,
    result_streamer_if.master                       m_if,
    output logic                                    busy_o,
    output logic                                    stream_done_o,
    output logic [RESULT_WIDTH+MEM3_ADDR_WIDTH-1:0] checksum_o
);
    localparam int unsigned     CntW    = $clog2(NUM_RESULTS + 1);
    localparam int unsigned     EntW    = RESULT_WIDTH + 1;
    localparam int unsigned     SumW    = RESULT_WIDTH + MEM3_ADDR_WIDTH;
    localparam logic [CntW-1:0] NumRes  = CntW'(NUM_RESULTS);
    localparam logic [CntW-1:0] LastIdx = CntW'(NUM_RESULTS - 1);

    typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

    state_e          state_q, state_d;
    logic            wd_q;
    logic [CntW-1:0] issued_q, issued_d;
    logic            inflight_q, inflight_last_q;
    logic [EntW-1:0] buf_q [2];
    logic            head_q;
    logic [1:0]      count_q, count_d;
    logic            stream_done_q;

    logic            start, pop, push, bypass, head_last;
    logic [2:0]      credit;
    logic [EntW-1:0] head_ent;

    assign start = writer_done_i & ~wd_q & (state_q == StIdle);

    // A word arriving from memory into an empty buffer is presented directly,
    // so the in-flight read counts as the head entry.
    assign bypass    = (count_q == 2'd0) & inflight_q;
    assign head_ent  = bypass ? {inflight_last_q, result_out_i} : buf_q[head_q];
    assign head_last = head_ent[RESULT_WIDTH];

    assign m_if.valid = (count_q != 2'd0) | inflight_q;
    assign m_if.data  = head_ent[RESULT_WIDTH-1:0];
    assign m_if.last  = head_last;

    assign pop    = m_if.valid & m_if.ready;
    assign push   = inflight_q & ~(bypass & pop);
    assign credit = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};

    assign read_en_o     = (state_q == StStream) & (issued_q < NumRes) & (credit < 3'd2);
    assign read_addr_o   = MEM3_ADDR_WIDTH'(issued_q);
    assign busy_o        = (state_q != StIdle);
    assign stream_done_o = stream_done_q;

    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop & ~bypass};
        if (start) begin
            issued_d = '0;
        end else if (read_en_o) begin
            issued_d = issued_q + CntW'(1);
        end
        unique case (state_q)
            StIdle:   if (start) state_d = StStream;
            StStream: if (read_en_o && issued_q == LastIdx) state_d = StDrain;
            StDrain:  if (pop && head_last) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            wd_q            <= 1'b1;  // a level already high out of reset is not an edge
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            head_q          <= 1'b0;
            count_q         <= 2'd0;
            stream_done_q   <= 1'b0;
            buf_q[0]        <= '0;
            buf_q[1]        <= '0;
        end else begin
            state_q         <= state_d;
            wd_q            <= writer_done_i;
            issued_q        <= issued_d;
            inflight_q      <= read_en_o;
            inflight_last_q <= read_en_o & (issued_q == LastIdx);
            head_q          <= head_q ^ (pop & ~bypass);
            count_q         <= count_d;
            stream_done_q   <= pop & head_last;
            if (push) begin
                buf_q[head_q ^ count_q[0]] <= {inflight_last_q, result_out_i};
            end
        end
    end

`ifdef RESULT_CHECKSUM_EN
    logic [SumW-1:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (start) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_q + SumW'(head_ent[RESULT_WIDTH-1:0]);
        end
    end

    assign checksum_o = sum_q;
`else
    assign checksum_o = '0;
`endif
endmodule

// File: tb/tb_result_streamer.sv
// Randomized bench for result_streamer: a 4-word instance and a 1-word instance,
// each fed by a bench-side memory and checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_result_streamer;
    localparam int unsigned W  = 18;
    localparam int unsigned AW = 4;
    localparam int unsigned SW = W + AW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic          wd4, rd4, busy4, done4;
    logic [AW-1:0] addr4;
    logic [W-1:0]  rout4;
    logic [SW-1:0] sum4;
    logic [W-1:0]  mem4 [4];
    result_streamer_if #(.DataWidth(W)) s4 ();

    logic          wd1, rd1, busy1, done1;
    logic [AW-1:0] addr1;
    logic [W-1:0]  rout1;
    logic [SW-1:0] sum1;
    logic [W-1:0]  mem1;
    result_streamer_if #(.DataWidth(W)) s1 ();

    result_streamer #(.RESULT_WIDTH(W), .MEM3_ADDR_WIDTH(AW), .NUM_RESULTS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .writer_done_i(wd4), .read_en_o(rd4), .read_addr_o(addr4),
        .result_out_i(rout4), .m_if(s4), .busy_o(busy4), .stream_done_o(done4),
        .checksum_o(sum4)
    );

    result_streamer #(.RESULT_WIDTH(W), .MEM3_ADDR_WIDTH(AW), .NUM_RESULTS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .writer_done_i(wd1), .read_en_o(rd1), .read_addr_o(addr1),
        .result_out_i(rout1), .m_if(s1), .busy_o(busy1), .stream_done_o(done1),
        .checksum_o(sum1)
    );

    // Memories with one cycle of read latency.
    always @(posedge clk) if (rd4) rout4 <= (addr4 < 4) ? mem4[addr4[1:0]] : '0;
    always @(posedge clk) if (rd1) rout1 <= (addr1 == 0) ? mem1 : '0;

    // Observations of dut4 for the current cycle.
    logic         o_v, o_l, o_rd, o_busy, o_done;
    logic [W-1:0] o_d;
    logic [AW-1:0] o_a;
    logic [SW-1:0] o_sum;

    // Frame record filled by run_frame4.
    int           r_addr[$];
    int           r_rd_k[$];
    int           r_valid_k[$];
    logic [W-1:0] r_data[$];
    logic         r_last[$];
    int           r_credit_viol, r_stall_viol, r_reads_stall, r_done_k;
    logic         r_busy0, r_busy_done;
    logic [SW-1:0] r_sum;

    function automatic logic [SW-1:0] exp_sum4();
        logic [SW-1:0] s = '0;
`ifdef RESULT_CHECKSUM_EN
        for (int i = 0; i < 4; i++) s += SW'(mem4[i]);
`endif
        return s;
    endfunction

    task automatic cyc4(input logic rdy);
        @(negedge clk);
        s4.ready = rdy;
        #1;
        o_v = s4.valid; o_d = s4.data; o_l = s4.last; o_rd = rd4; o_a = addr4;
        o_busy = busy4; o_done = done4; o_sum = sum4;
    endtask

    // Raises writer_done and records one frame; mode 0 ready=1, 1 toggling,
    // 2 stalled for 10 cycles, 3 random. pulse_k re-pulses writer_done mid-frame.
    task automatic run_frame4(input int mode, input int pulse_k, input int budget);
        int   outst = 0;
        logic pstall = 1'b0;
        logic [W-1:0] pd = '0;
        logic pl = 1'b0;
        logic rdy;
        r_addr.delete(); r_rd_k.delete(); r_valid_k.delete(); r_data.delete(); r_last.delete();
        r_credit_viol = 0; r_stall_viol = 0; r_reads_stall = 0; r_done_k = -1;
        r_busy0 = 1'b0; r_busy_done = 1'b1; r_sum = '1;
        @(negedge clk); wd4 = 1'b0;
        @(negedge clk); wd4 = 1'b1;
        for (int k = 0; k < budget; k++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 2 == 0);
                2:       rdy = (k >= 10);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (k == pulse_k) wd4 = 1'b0;
            if (k == pulse_k + 1) wd4 = 1'b1;
            cyc4(rdy);
            if (k == 0) r_busy0 = o_busy;
            if (o_rd) begin
                r_addr.push_back(int'(o_a));
                r_rd_k.push_back(k);
                if (outst - int'(o_v && rdy) >= 2) r_credit_viol++;
            end
            if (pstall && (!o_v || o_d !== pd || o_l !== pl)) r_stall_viol++;
            if (mode == 2 && k < 10 && o_rd) r_reads_stall++;
            if (o_v && rdy) begin
                r_data.push_back(o_d); r_last.push_back(o_l); r_valid_k.push_back(k);
            end
            outst = outst + int'(o_rd) - int'(o_v && rdy);
            pstall = o_v && !rdy; pd = o_d; pl = o_l;
            if (o_done) begin
                r_done_k = k; r_sum = o_sum; r_busy_done = o_busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wd4 = 1'b0; wd1 = 1'b0; s4.ready = 1'b0; s1.ready = 1'b0;
        #12;
        total++; if ({rd4, busy4, done4, s4.valid, s4.last} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00000", {rd4, busy4, done4, s4.valid, s4.last});
        end
        total++; if (s4.data !== '0 || addr4 !== '0) begin
            bad++; $display("FAIL reset_data: data=%0h addr=%0h want 0", s4.data, addr4);
        end
        total++; if (sum4 !== '0) begin
            bad++; $display("FAIL reset_sum: got %0h want 0", sum4);
        end
        total++; if ({rd1, busy1, done1, s1.valid} !== 4'b0) begin
            bad++; $display("FAIL reset_dut1: got %b want 0000", {rd1, busy1, done1, s1.valid});
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) cyc4(1'b1);
        total++; if (o_busy !== 1'b0 || o_rd !== 1'b0) begin
            bad++; $display("FAIL idle_no_edge: busy=%b read_en=%b want 0", o_busy, o_rd);
        end
    endtask

    task automatic test_stream();
        mem4[0] = 5; mem4[1] = 10; mem4[2] = 15; mem4[3] = 20;
        run_frame4(0, -1, 40);
        total++; if (r_busy0 !== 1'b1) begin
            bad++; $display("FAIL busy_latency: got %b want 1", r_busy0);
        end
        total++; if (r_addr.size() != 4) begin
            bad++; $display("FAIL read_count: got %0d want 4", r_addr.size());
        end
        for (int i = 0; i < r_addr.size() && i < 4; i++) begin
            total++; if (r_addr[i] != i || r_rd_k[i] != i) begin
                bad++; $display("FAIL read_seq[%0d]: addr=%0d cyc=%0d want %0d", i, r_addr[i], r_rd_k[i], i);
            end
        end
        total++; if (r_data.size() != 4) begin
            bad++; $display("FAIL beat_count: got %0d want 4", r_data.size());
        end
        for (int i = 0; i < r_data.size() && i < 4; i++) begin
            total++; if (r_data[i] !== mem4[i] || r_last[i] !== (i == 3) || r_valid_k[i] != i + 1) begin
                bad++; $display("FAIL beat[%0d]: data=%0d last=%b cyc=%0d want %0d %b %0d",
                                i, r_data[i], r_last[i], r_valid_k[i], mem4[i], (i == 3), i + 1);
            end
        end
        total++; if (r_done_k != 5 || r_busy_done !== 1'b0) begin
            bad++; $display("FAIL done_timing: cyc=%0d busy=%b want 5 0", r_done_k, r_busy_done);
        end
        total++; if (r_sum !== exp_sum4()) begin
            bad++; $display("FAIL checksum_basic: got %0d want %0d", r_sum, exp_sum4());
        end
        cyc4(1'b1);
        total++; if (o_done !== 1'b0) begin
            bad++; $display("FAIL done_pulse_width: got %b want 0", o_done);
        end
        wd4 = 1'b0;
    endtask

    task automatic test_toggle();
        mem4[0] = 5; mem4[1] = 10; mem4[2] = 15; mem4[3] = 20;
        run_frame4(1, -1, 60);
        total++; if (r_data.size() != 4 || r_done_k < 0) begin
            bad++; $display("FAIL toggle_count: beats=%0d done_cyc=%0d want 4 and done", r_data.size(), r_done_k);
        end
        for (int i = 0; i < r_data.size() && i < 4; i++) begin
            total++; if (r_data[i] !== mem4[i] || r_last[i] !== (i == 3)) begin
                bad++; $display("FAIL toggle_beat[%0d]: data=%0d last=%b want %0d %b", i, r_data[i], r_last[i], mem4[i], (i == 3));
            end
        end
        total++; if (r_credit_viol != 0 || r_stall_viol != 0) begin
            bad++; $display("FAIL toggle_flow: credit=%0d stall=%0d want 0 0", r_credit_viol, r_stall_viol);
        end
        wd4 = 1'b0;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) mem4[i] = W'($urandom);
        run_frame4(2, -1, 60);
        total++; if (r_reads_stall != 2) begin
            bad++; $display("FAIL stall_reads: got %0d want 2", r_reads_stall);
        end
        total++; if (r_addr.size() != 4 || r_data.size() != 4) begin
            bad++; $display("FAIL stall_count: reads=%0d beats=%0d want 4 4", r_addr.size(), r_data.size());
        end
        for (int i = 0; i < r_data.size() && i < 4; i++) begin
            total++; if (r_data[i] !== mem4[i] || r_addr[i] != i) begin
                bad++; $display("FAIL stall_order[%0d]: data=%0h addr=%0d want %0h %0d", i, r_data[i], r_addr[i], mem4[i], i);
            end
        end
        total++; if (r_stall_viol != 0 || r_credit_viol != 0 || r_sum !== exp_sum4()) begin
            bad++; $display("FAIL stall_flow: stall=%0d credit=%0d sum=%0h want 0 0 %0h", r_stall_viol, r_credit_viol, r_sum, exp_sum4());
        end
        wd4 = 1'b0;
    endtask

    task automatic test_retrigger();
        int act;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++) mem4[i] = W'($urandom);
            run_frame4(0, 2, 40);
            total++; if (r_data.size() != 4 || r_done_k != 5) begin
                bad++; $display("FAIL retrig_frame%0d: beats=%0d done_cyc=%0d want 4 5", f, r_data.size(), r_done_k);
            end
            for (int i = 0; i < r_data.size() && i < 4; i++) begin
                total++; if (r_data[i] !== mem4[i]) begin
                    bad++; $display("FAIL retrig_beat%0d[%0d]: got %0h want %0h", f, i, r_data[i], mem4[i]);
                end
            end
            act = 0;
            repeat (10) begin
                cyc4(1'b1);
                if (o_busy || o_rd || o_v || o_done) act++;
            end
            total++; if (act != 0) begin
                bad++; $display("FAIL retrig_held_high%0d: active cycles=%0d want 0", f, act);
            end
        end
        wd4 = 1'b0;
    endtask

    task automatic test_mid_reset();
        int acc = 0;
        int act = 0;
        for (int i = 0; i < 4; i++) mem4[i] = W'($urandom);
        @(negedge clk); wd4 = 1'b0;
        @(negedge clk); wd4 = 1'b1;
        for (int k = 0; k < 20 && acc < 2; k++) begin
            cyc4(1'b1);
            if (o_v) acc++;
        end
        total++; if (acc != 2) begin
            bad++; $display("FAIL midrst_accept: got %0d want 2", acc);
        end
        @(negedge clk); rst_n = 1'b0;
        #1;
        total++; if ({rd4, busy4, done4, s4.valid, s4.last} !== 5'b0 || s4.data !== '0 || addr4 !== '0) begin
            bad++; $display("FAIL midrst_clear: ctrl=%b data=%0h addr=%0h want 0",
                            {rd4, busy4, done4, s4.valid, s4.last}, s4.data, addr4);
        end
        total++; if (sum4 !== '0) begin
            bad++; $display("FAIL midrst_sum: got %0h want 0", sum4);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            cyc4(1'b1);
            if (o_busy || o_rd || o_v || o_done) act++;
        end
        total++; if (act != 0) begin
            bad++; $display("FAIL midrst_no_restart: active cycles=%0d want 0", act);
        end
        for (int i = 0; i < 4; i++) mem4[i] = W'($urandom);
        run_frame4(0, -1, 40);
        total++; if (r_addr.size() != 4 || r_addr[0] != 0 || r_data.size() != 4 || r_done_k != 5) begin
            bad++; $display("FAIL midrst_restart: reads=%0d beats=%0d done_cyc=%0d want 4 4 5",
                            r_addr.size(), r_data.size(), r_done_k);
        end
        for (int i = 0; i < r_data.size() && i < 4; i++) begin
            total++; if (r_data[i] !== mem4[i] || r_last[i] !== (i == 3)) begin
                bad++; $display("FAIL midrst_beat[%0d]: data=%0h last=%b want %0h %b", i, r_data[i], r_last[i], mem4[i], (i == 3));
            end
        end
        wd4 = 1'b0;
    endtask

    task automatic test_single();
        int           beats = 0;
        int           done_k = -1;
        logic [W-1:0] d = '0;
        logic         l = 1'b0;
        logic [SW-1:0] s = '1;
        logic [SW-1:0] exp_s = '0;
        mem1 = 18'h3FFFF;
`ifdef RESULT_CHECKSUM_EN
        exp_s = SW'(mem1);
`endif
        @(negedge clk); wd1 = 1'b1;
        for (int k = 0; k < 12 && done_k < 0; k++) begin
            @(negedge clk); s1.ready = 1'b1; #1;
            if (rd1 && addr1 !== '0) begin
                total++; bad++; $display("FAIL single_addr: got %0d want 0", addr1);
            end
            if (s1.valid) begin beats++; d = s1.data; l = s1.last; end
            if (done1) begin done_k = k; s = sum1; end
        end
        total++; if (beats != 1 || d !== 18'h3FFFF || l !== 1'b1) begin
            bad++; $display("FAIL single_beat: beats=%0d data=%0h last=%b want 1 3ffff 1", beats, d, l);
        end
        total++; if (done_k != 2 || s !== exp_s) begin
            bad++; $display("FAIL single_done: cyc=%0d sum=%0h want 2 %0h", done_k, s, exp_s);
        end
        wd1 = 1'b0;
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 4; i++) mem4[i] = W'($urandom);
            run_frame4(3, -1, 300);
            total++; if (r_data.size() != 4 || r_done_k < 0) begin
                bad++; $display("FAIL rand%0d_count: beats=%0d done_cyc=%0d want 4 and done", f, r_data.size(), r_done_k);
            end
            for (int i = 0; i < r_data.size() && i < 4; i++) begin
                total++; if (r_data[i] !== mem4[i] || r_last[i] !== (i == 3)) begin
                    bad++; $display("FAIL rand%0d_beat[%0d]: data=%0h last=%b want %0h %b", f, i, r_data[i], r_last[i], mem4[i], (i == 3));
                end
            end
            total++; if (r_credit_viol != 0 || r_stall_viol != 0 || r_sum !== exp_sum4()) begin
                bad++; $display("FAIL rand%0d_flow: credit=%0d stall=%0d sum=%0h want 0 0 %0h",
                                f, r_credit_viol, r_stall_viol, r_sum, exp_sum4());
            end
            wd4 = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_toggle();
        test_stall();
        test_retrigger();
        test_mid_reset();
        test_single();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
